// File: rtl/dbus_axi_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dbus_axi_bridge_pkg
// Purpose  : Shared bridge FSM state encoding and single-beat AXI constants.
// Revision : 1.0
// ============================================================================
package dbus_axi_bridge_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_AR   = 3'd1,
    S_R    = 3'd2,
    S_AW_W = 3'd3,
    S_B    = 3'd4,
    S_DONE = 3'd5
  } state_t;

  localparam logic [1:0] c_burst_incr = 2'b01;
  localparam logic [3:0] c_len_single = 4'd0;

endpackage : dbus_axi_bridge_pkg
`default_nettype wire

// File: rtl/dbus_axi_bridge_if.sv
`default_nettype none
// ============================================================================
// Module   : dbus_axi_bridge_if
// Purpose  : Data-bus request side plus AXI3 channels seen by the bridge.
// Revision : 1.0
// ============================================================================
interface dbus_axi_bridge_if;

  logic        data_req;
  logic        data_wr;
  logic [2:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [3:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;

  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [3:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic [1:0]  awlock;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;

  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;

  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  // Bridge side: consumes data-bus requests, masters the AXI channels.
  modport master (
    input  data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    output data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );

endinterface : dbus_axi_bridge_if
`default_nettype wire

// File: rtl/dbus_axi_bridge.sv
`default_nettype none
// ============================================================================
// Module   : dbus_axi_bridge
// Purpose  : Single-outstanding data-bus to AXI3 bridge, one beat per access.
// Revision : 1.0
// ============================================================================
module dbus_axi_bridge
  import dbus_axi_bridge_pkg::*;
#(
  parameter logic [3:0] AXI_ID = 4'd1
) (
  input  wire logic       clk,
  input  wire logic       reset,
  dbus_axi_bridge_if.master bus
);

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic [1:0]  r_size;
  logic [3:0]  r_wstrb;
  logic        r_aw_done;
  logic        r_w_done;

  logic        w_accept;
  logic        w_arvalid;
  logic        w_rready;
  logic        w_awvalid;
  logic        w_wvalid;
  logic        w_bready;
  logic        w_data_ok;
  logic        w_aw_fire;
  logic        w_w_fire;

  assign w_accept = bus.data_req && (r_state == S_IDLE);

  always_comb begin
    w_next    = r_state;
    w_arvalid = 1'b0;
    w_rready  = 1'b0;
    w_awvalid = 1'b0;
    w_wvalid  = 1'b0;
    w_bready  = 1'b0;
    w_data_ok = 1'b0;
    w_aw_fire = 1'b0;
    w_w_fire  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.data_req) w_next = bus.data_wr ? S_AW_W : S_AR;
      end
      S_AR: begin
        w_arvalid = 1'b1;
        if (bus.arready) w_next = S_R;
      end
      S_R: begin
        w_rready = 1'b1;
        if (bus.rvalid) w_next = S_DONE;
      end
      S_AW_W: begin
        // Each channel retires independently; leave once both have, possibly together.
        w_awvalid = !r_aw_done;
        w_wvalid  = !r_w_done;
        w_aw_fire = w_awvalid && bus.awready;
        w_w_fire  = w_wvalid && bus.wready;
        if ((r_aw_done || w_aw_fire) && (r_w_done || w_w_fire)) w_next = S_B;
      end
      S_B: begin
        w_bready = 1'b1;
        if (bus.bvalid) w_next = S_DONE;
      end
      S_DONE: begin
        w_data_ok = 1'b1;
        w_next    = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_size    <= '0;
      r_wstrb   <= '0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_addr    <= bus.data_addr;
        r_size    <= bus.data_size[1:0];
        r_wstrb   <= bus.data_wstrb;
        r_wdata   <= bus.data_wdata;
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
      end
      if (r_state == S_AW_W) begin
        if (w_next == S_B) begin
          r_aw_done <= 1'b0;
          r_w_done  <= 1'b0;
        end else begin
          r_aw_done <= r_aw_done | w_aw_fire;
          r_w_done  <= r_w_done | w_w_fire;
        end
      end
      if ((r_state == S_R) && bus.rvalid) r_rdata <= bus.rdata;
    end
  end

  assign bus.data_addr_ok = w_accept;
  assign bus.data_data_ok = w_data_ok;
  assign bus.data_rdata   = r_rdata;

  assign bus.arid    = AXI_ID;
  assign bus.araddr  = r_addr;
  assign bus.arlen   = c_len_single;
  assign bus.arsize  = {1'b0, r_size};
  assign bus.arburst = c_burst_incr;
  assign bus.arlock  = 2'b00;
  assign bus.arcache = 4'b0000;
  assign bus.arprot  = 3'b000;
  assign bus.arvalid = w_arvalid;
  assign bus.rready  = w_rready;

  assign bus.awid    = AXI_ID;
  assign bus.awaddr  = r_addr;
  assign bus.awlen   = c_len_single;
  assign bus.awsize  = {1'b0, r_size};
  assign bus.awburst = c_burst_incr;
  assign bus.awlock  = 2'b00;
  assign bus.awcache = 4'b0000;
  assign bus.awprot  = 3'b000;
  assign bus.awvalid = w_awvalid;

  assign bus.wid    = AXI_ID;
  assign bus.wdata  = r_wdata;
  assign bus.wstrb  = r_wstrb;
  assign bus.wlast  = 1'b1;
  assign bus.wvalid = w_wvalid;
  assign bus.bready = w_bready;

endmodule : dbus_axi_bridge
`default_nettype wire

// File: tb/tb_dbus_axi_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_dbus_axi_bridge
// Purpose  : Directed self-checking bench for dbus_axi_bridge.
// Revision : 1.0
// ============================================================================
module tb_dbus_axi_bridge;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dbus_axi_bridge_if bus ();

  dbus_axi_bridge #(.AXI_ID(4'd1)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] rdata;
    logic [2:0]  exp_arsize;
  } rd_vec_t;

  rd_vec_t vecs [4];

  task automatic idle_inputs();
    bus.data_req   = 1'b0;
    bus.data_wr    = 1'b0;
    bus.data_size  = 3'd0;
    bus.data_wstrb = 4'h0;
    bus.data_addr  = 32'h0;
    bus.data_wdata = 32'h0;
    bus.arready    = 1'b0;
    bus.rid        = 4'd1;
    bus.rdata      = 32'h0;
    bus.rresp      = 2'b00;
    bus.rlast      = 1'b1;
    bus.rvalid     = 1'b0;
    bus.awready    = 1'b0;
    bus.wready     = 1'b0;
    bus.bid        = 4'd1;
    bus.bresp      = 2'b00;
    bus.bvalid     = 1'b0;
  endtask

  // Read with arready/rvalid offered from acceptance on; lat is cycles to data_data_ok.
  task automatic do_read(input logic [31:0] addr, input logic [2:0] size, input logic [31:0] rdata,
                         output int lat, output logic [31:0] c_addr, output logic [2:0] c_size,
                         output logic [3:0] c_len, output logic [1:0] c_burst, output logic [3:0] c_id);
    bit seen = 1'b0;
    lat = -1; c_addr = '0; c_size = '0; c_len = 4'hF; c_burst = '0; c_id = '0;
    @(negedge clk);
    bus.data_req = 1'b1; bus.data_wr = 1'b0; bus.data_addr = addr; bus.data_size = size;
    bus.arready = 1'b1; bus.rvalid = 1'b1; bus.rdata = rdata;
    #1 chk("rd_addr_ok", {31'b0, bus.data_addr_ok}, 32'd1);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      bus.data_req = 1'b0;
      #1;
      if (bus.arvalid && !seen) begin
        seen = 1'b1; c_addr = bus.araddr; c_size = bus.arsize;
        c_len = bus.arlen; c_burst = bus.arburst; c_id = bus.arid;
      end
      if (bus.data_data_ok) begin lat = k; break; end
    end
    bus.arready = 1'b0; bus.rvalid = 1'b0;
    @(negedge clk);
    #1 chk("rd_single_pulse", {31'b0, bus.data_data_ok}, 32'd0);
  endtask

  // Write where awready/wready/bvalid rise at cycles aw_k/w_k/b_k after acceptance.
  task automatic do_write(input logic [31:0] addr, input logic [3:0] strb, input logic [31:0] data,
                          input int aw_k, input int w_k, input int b_k,
                          output int lat, output int aw_hs, output int w_hs, output int n_ok,
                          output logic [31:0] c_awaddr, output logic [2:0] c_awsize,
                          output logic [31:0] c_wdata, output logic [3:0] c_wstrb,
                          output logic c_wlast, output logic [3:0] c_wid);
    bit aw_seen = 1'b0;
    bit w_seen  = 1'b0;
    lat = -1; aw_hs = 0; w_hs = 0; n_ok = 0;
    c_awaddr = '0; c_awsize = '0; c_wdata = '0; c_wstrb = '0; c_wlast = 1'b0; c_wid = '0;
    @(negedge clk);
    bus.data_req = 1'b1; bus.data_wr = 1'b1; bus.data_addr = addr; bus.data_size = 3'd2;
    bus.data_wstrb = strb; bus.data_wdata = data;
    #1 chk("wr_addr_ok", {31'b0, bus.data_addr_ok}, 32'd1);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      bus.data_req = 1'b0;
      bus.awready  = (k >= aw_k);
      bus.wready   = (k >= w_k);
      bus.bvalid   = (k >= b_k);
      #1;
      if (bus.awvalid && !aw_seen) begin
        aw_seen = 1'b1; c_awaddr = bus.awaddr; c_awsize = bus.awsize;
      end
      if (bus.wvalid && !w_seen) begin
        w_seen = 1'b1; c_wdata = bus.wdata; c_wstrb = bus.wstrb; c_wlast = bus.wlast; c_wid = bus.wid;
      end
      if (bus.awvalid && bus.awready) aw_hs++;
      if (bus.wvalid && bus.wready) w_hs++;
      if (bus.data_data_ok) begin
        if (lat < 0) lat = k;
        n_ok++;
      end
    end
    bus.awready = 1'b0; bus.wready = 1'b0; bus.bvalid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat, aw_hs, w_hs, n_ok;
    logic [31:0] c_addr, c_wdata;
    logic [2:0]  c_size;
    logic [3:0]  c_len, c_id, c_wstrb;
    logic [1:0]  c_burst;
    logic        c_wlast;
    int          acc, nd, ar_hs, stable_bad, ok_seen;
    int          acc_cyc [2];
    int          ok_cyc  [2];

    vecs[0] = '{addr: 32'h1FC0_0004, size: 3'd2,   rdata: 32'hDEAD_BEEF, exp_arsize: 3'd2};
    vecs[1] = '{addr: 32'h1FC0_0003, size: 3'd0,   rdata: 32'h0000_00A5, exp_arsize: 3'd0};
    vecs[2] = '{addr: 32'h0000_1002, size: 3'd1,   rdata: 32'h1234_ABCD, exp_arsize: 3'd1};
    vecs[3] = '{addr: 32'hBFC0_0100, size: 3'b110, rdata: 32'h0F0F_F0F0, exp_arsize: 3'd2};

    idle_inputs();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_arvalid",  {31'b0, bus.arvalid},      32'd0);
    chk("rst_rready",   {31'b0, bus.rready},       32'd0);
    chk("rst_awvalid",  {31'b0, bus.awvalid},      32'd0);
    chk("rst_wvalid",   {31'b0, bus.wvalid},       32'd0);
    chk("rst_bready",   {31'b0, bus.bready},       32'd0);
    chk("rst_addr_ok",  {31'b0, bus.data_addr_ok}, 32'd0);
    chk("rst_data_ok",  {31'b0, bus.data_data_ok}, 32'd0);
    chk("rst_rdata",    bus.data_rdata,            32'd0);
    reset = 1'b0;

    for (int i = 0; i < 4; i++) begin
      do_read(vecs[i].addr, vecs[i].size, vecs[i].rdata, lat, c_addr, c_size, c_len, c_burst, c_id);
      chk($sformatf("rd%0d_latency", i), lat,                        32'd3);
      chk($sformatf("rd%0d_araddr", i),  c_addr,                     vecs[i].addr);
      chk($sformatf("rd%0d_arsize", i),  {29'b0, c_size},            {29'b0, vecs[i].exp_arsize});
      chk($sformatf("rd%0d_arlen", i),   {28'b0, c_len},             32'd0);
      chk($sformatf("rd%0d_arburst", i), {30'b0, c_burst},           32'd1);
      chk($sformatf("rd%0d_arid", i),    {28'b0, c_id},              32'd1);
      chk($sformatf("rd%0d_rdata", i),   bus.data_rdata,             vecs[i].rdata);
    end

    // AW accepted two cycles before W; B arrives later still.
    do_write(32'h8000_0010, 4'hC, 32'h1234_5678, 1, 3, 5,
             lat, aw_hs, w_hs, n_ok, c_addr, c_size, c_wdata, c_wstrb, c_wlast, c_id);
    chk("wr0_aw_hs",   aw_hs,              32'd1);
    chk("wr0_w_hs",    w_hs,               32'd1);
    chk("wr0_data_ok", n_ok,               32'd1);
    chk("wr0_latency", lat,                32'd6);
    chk("wr0_awaddr",  c_addr,             32'h8000_0010);
    chk("wr0_awsize",  {29'b0, c_size},    32'd2);
    chk("wr0_wdata",   c_wdata,            32'h1234_5678);
    chk("wr0_wstrb",   {28'b0, c_wstrb},   32'hC);
    chk("wr0_wlast",   {31'b0, c_wlast},   32'd1);
    chk("wr0_wid",     {28'b0, c_id},      32'd1);

    do_write(32'h8000_0020, 4'hF, 32'hA5A5_5A5A, 1, 1, 1,
             lat, aw_hs, w_hs, n_ok, c_addr, c_size, c_wdata, c_wstrb, c_wlast, c_id);
    chk("wr1_same_cycle_latency", lat, 32'd3);
    chk("wr1_aw_hs", aw_hs, 32'd1);
    chk("wr1_w_hs",  w_hs,  32'd1);

    do_write(32'h8000_0030, 4'h1, 32'h0000_00EE, 2, 1, 1,
             lat, aw_hs, w_hs, n_ok, c_addr, c_size, c_wdata, c_wstrb, c_wlast, c_id);
    chk("wr2_w_first_latency", lat, 32'd4);
    chk("wr2_data_ok", n_ok, 32'd1);

    // data_req held across two back-to-back reads.
    acc = 0; nd = 0; ar_hs = 0;
    acc_cyc[0] = -1; acc_cyc[1] = -1; ok_cyc[0] = -1; ok_cyc[1] = -1;
    bus.arready = 1'b1; bus.rvalid = 1'b1; bus.rdata = 32'h0BAD_F00D;
    bus.data_wr = 1'b0; bus.data_addr = 32'h0000_0100; bus.data_size = 3'd2;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      bus.data_req = (acc < 2);
      #1;
      if (bus.arvalid && bus.arready) ar_hs++;
      if (bus.data_req && bus.data_addr_ok) begin
        if (acc < 2) acc_cyc[acc] = k;
        acc++;
      end
      if (bus.data_data_ok) begin
        if (nd < 2) ok_cyc[nd] = k;
        nd++;
      end
    end
    bus.data_req = 1'b0; bus.arready = 1'b0; bus.rvalid = 1'b0;
    chk("b2b_accepts",     acc,        32'd2);
    chk("b2b_ar_count",    ar_hs,      32'd2);
    chk("b2b_data_ok_cnt", nd,         32'd2);
    chk("b2b_first_ok",    ok_cyc[0],  32'd3);
    chk("b2b_second_acc",  acc_cyc[1], 32'd4);
    chk("b2b_second_ok",   ok_cyc[1],  32'd7);

    // AR stalled five cycles while the initiator keeps requesting.
    @(negedge clk);
    bus.data_req = 1'b1; bus.data_wr = 1'b0; bus.data_addr = 32'h2000_0040; bus.data_size = 3'd2;
    #1 chk("stall_accept", {31'b0, bus.data_addr_ok}, 32'd1);
    stable_bad = 0; ok_seen = 0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      bus.data_addr = 32'h3333_0000 + k;
      #1;
      if (!bus.arvalid || (bus.araddr !== 32'h2000_0040) || (bus.arsize !== 3'd2)) stable_bad++;
      if (bus.data_addr_ok) ok_seen++;
    end
    chk("stall_ar_stable",  stable_bad, 32'd0);
    chk("stall_no_addr_ok", ok_seen,    32'd0);
    @(negedge clk);
    bus.data_req = 1'b0; bus.arready = 1'b1; bus.rvalid = 1'b1; bus.rdata = 32'hCAFE_0001;
    nd = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      #1;
      if (bus.data_data_ok) nd++;
    end
    bus.arready = 1'b0; bus.rvalid = 1'b0;
    chk("stall_data_ok", nd,             32'd1);
    chk("stall_rdata",   bus.data_rdata, 32'hCAFE_0001);

    // Reset while waiting in R abandons the read.
    @(negedge clk);
    bus.data_req = 1'b1; bus.data_wr = 1'b0; bus.data_addr = 32'h4000_0000; bus.data_size = 3'd2;
    bus.arready = 1'b1; bus.rvalid = 1'b0;
    @(negedge clk);
    bus.data_req = 1'b0;
    @(negedge clk);
    bus.arready = 1'b0;
    #1 chk("rstR_in_R", {31'b0, bus.rready}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rstR_rready",  {31'b0, bus.rready},       32'd0);
    chk("rstR_arvalid", {31'b0, bus.arvalid},      32'd0);
    chk("rstR_data_ok", {31'b0, bus.data_data_ok}, 32'd0);
    chk("rstR_rdata",   bus.data_rdata,            32'd0);
    bus.rvalid = 1'b1; bus.rdata = 32'h5555_AAAA;
    nd = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      #1;
      if (bus.data_data_ok) nd++;
    end
    bus.rvalid = 1'b0;
    chk("rstR_no_data_ok", nd, 32'd0);

    do_read(32'h1FC0_0008, 3'd2, 32'h7777_1111, lat, c_addr, c_size, c_len, c_burst, c_id);
    chk("post_rst_latency", lat,            32'd3);
    chk("post_rst_rdata",   bus.data_rdata, 32'h7777_1111);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_dbus_axi_bridge
`default_nettype wire

// File: doc/dbus_axi_bridge.md
DBUS_AXI_BRIDGE -- requirements
Module: dbus_axi_bridge

Interface
REQ-001 Parameter AXI_ID, default 4'd1, meaning ID driven on arid/awid/wid.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high.
REQ-004 data_req  input  1  request valid from the data-bus initiator.
REQ-005 data_wr  input  1  1 = write, 0 = read.
REQ-006 data_size  input  3  byte count code: 0 = 1 B, 1 = 2 B, 2 = 4 B.
REQ-007 data_wstrb  input  4  byte enables for writes.
REQ-008 data_addr  input  32  physical address.
REQ-009 data_wdata  input  32  write data.
REQ-010 data_addr_ok  output  1  request accepted this cycle.
REQ-011 data_data_ok  output  1  one-cycle completion pulse.
REQ-012 data_rdata  output  32  read data, valid while data_data_ok.
REQ-013 AR channel: arid 4, araddr 32, arlen 4, arsize 3, arburst 2, arvalid 1 out; arready 1 in.
REQ-014 R channel: rid 4, rdata 32, rresp 2, rlast 1, rvalid 1 in; rready 1 out.
REQ-015 AW channel: awid 4, awaddr 32, awlen 4, awsize 3, awburst 2, awvalid 1 out; awready 1 in.
REQ-016 W channel: wid 4, wdata 32, wstrb 4, wlast 1, wvalid 1 out; wready 1 in.
REQ-017 B channel: bid 4, bresp 2, bvalid 1 in; bready 1 out.
REQ-018 arlock/awlock 2, arcache/awcache 4, arprot/awprot 3 outputs, tied to 0.

Function
REQ-019 At most one outstanding transaction; states IDLE, AR, R, AW_W, B, DONE.
REQ-020 data_addr_ok = data_req && state==IDLE, combinational; acceptance = data_req && data_addr_ok.
REQ-021 On acceptance, register addr/size/wstrb/wdata/wr; next state AR if read, AW_W if write.
REQ-022 AR: arvalid=1 with registered request; on arvalid&&arready -> R.
REQ-023 R: rready=1; on rvalid, latch rdata -> DONE.
REQ-024 AW_W: awvalid and wvalid asserted together; per-channel done flags; each valid drops after its own handshake; -> B when both done (including same-cycle).
REQ-025 B: bready=1; on bvalid -> DONE.
REQ-026 DONE: data_data_ok=1 for exactly one cycle -> IDLE; no new request accepted in DONE.
REQ-027 Minimum read latency, acceptance to data_data_ok: 3 cycles with arready/rvalid returned immediately.
REQ-028 arlen=awlen=0, arburst=awburst=2'b01, wlast=1, arsize=awsize={1'b0,data_size[1:0]}.
REQ-029 data_rdata holds the last read value until the next read completes; value after a write is don't-care.
REQ-030 Every accepted request receives exactly one data_data_ok; no cancel input (initiator discards stale responses).
REQ-031 rresp/bresp/rid/bid/rlast are ignored.
REQ-032 valid signals, once raised, stay high and payload stable until their handshake.

Reset
REQ-033 Reset -> IDLE and clears done flags; all valid/ready outputs, data_addr_ok, and data_data_ok are 0; data_rdata = 0.
REQ-034 Reset mid-transaction abandons it with no data_data_ok.

Structure
REQ-035 State enum and AXI constants (burst INCR, len 0) live in the shared cpu package.
REQ-036 Single flat module; no sub-modules.

Verification
REQ-037 Read 0x1FC0_0004, size 2, arready/rvalid immediate, rdata 0xDEADBEEF -> data_data_ok 3 cycles after acceptance, data_rdata 0xDEADBEEF.
REQ-038 Write 0x8000_0010, wstrb 4'hC, wdata 0x12345678; awready 2 cycles before wready -> aw/w handshakes occur once each, awsize 2, single data_data_ok after bvalid.
REQ-039 data_req held high across 2 back-to-back reads -> second addr_ok only after first data_data_ok; 2 ARs total.
REQ-040 arready held 0 for 5 cycles -> arvalid/araddr stable throughout; data_addr_ok stays 0.
REQ-041 Reset asserted in R state -> next cycle IDLE, rready 0, no data_data_ok.
REQ-042 size 0 read at 0x...3 -> arsize 0, araddr unchanged 0x...3.
